// File: rtl/serv_ibus_fetch.sv
// SERV instruction fetch: single-beat Wishbone reads on demand. Defining
// SERV_IBUS_PREFETCH_EN adds a one-word speculative prefetch buffer.
module serv_ibus_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_fetch_req,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic [31:0] o_ibus_adr,
    output logic        o_ibus_cyc,
    input  logic [31:0] i_ibus_rdt,
    input  logic        i_ibus_ack,
    output logic [29:0] o_wb_rdt,
    output logic        o_wb_en
);

`ifdef SERV_IBUS_PREFETCH_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DEMAND = 2'd1, SPEC = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DEMAND = 2'd1} state_t;
`endif

    state_t      state;
    logic [29:0] req_tag;
    logic        unused_bits;

    assign req_tag = i_pc[31:2];

`ifdef SERV_IBUS_PREFETCH_EN
    logic        buf_vld;
    logic        launch;
    logic        pend;
    logic        discard;
    logic [29:0] buf_tag;
    logic [29:0] buf_dat;
    logic [29:0] pend_tag;
    logic [29:0] nxt_tag;
    logic        hit;
    logic        pend_any;
    logic        drop;
    logic        spec_match;
    logic [29:0] pend_sel;

    // A hit while a word is still being presented is served as a miss so
    // that o_wb_en can never be high on two consecutive cycles.
    assign hit        = buf_vld & ~i_flush & ~o_wb_en & (buf_tag == req_tag);
    assign pend_any   = pend | i_fetch_req;
    assign pend_sel   = pend ? pend_tag : req_tag;
    assign drop       = discard | i_flush;
    assign spec_match = ~drop & (pend_sel == o_ibus_adr[31:2]);
    assign unused_bits = ^{i_pc[1:0], i_ibus_rdt[1:0]};

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            o_ibus_cyc <= 1'b0;
            o_ibus_adr <= '0;
            o_wb_en    <= 1'b0;
            o_wb_rdt   <= '0;
            buf_vld    <= 1'b0;
            launch     <= 1'b1;
            pend       <= 1'b0;
            discard    <= 1'b0;
            nxt_tag    <= RESET_PC[31:2];
        end else begin
            o_wb_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_flush)
                        buf_vld <= 1'b0;
                    if (i_fetch_req) begin
                        if (hit) begin
                            o_wb_en  <= 1'b1;
                            o_wb_rdt <= buf_dat;
                            launch   <= 1'b1;
                            nxt_tag  <= req_tag + 30'd1;
                        end else begin
                            launch     <= 1'b0;
                            state      <= DEMAND;
                            o_ibus_cyc <= 1'b1;
                            o_ibus_adr <= {req_tag, 2'b00};
                        end
                    end else if (launch) begin
                        launch     <= 1'b0;
                        state      <= SPEC;
                        o_ibus_cyc <= 1'b1;
                        o_ibus_adr <= {nxt_tag, 2'b00};
                        buf_vld    <= 1'b0;
                        pend       <= 1'b0;
                        discard    <= 1'b0;
                    end
                end
                DEMAND: begin
                    if (i_flush)
                        buf_vld <= 1'b0;
                    if (i_ibus_ack) begin
                        state      <= IDLE;
                        o_ibus_cyc <= 1'b0;
                        o_wb_en    <= 1'b1;
                        o_wb_rdt   <= i_ibus_rdt[31:2];
                        launch     <= 1'b1;
                        nxt_tag    <= o_ibus_adr[31:2] + 30'd1;
                    end
                end
                SPEC: begin
                    if (i_flush)
                        discard <= 1'b1;
                    if (i_fetch_req && !pend)
                        pend <= 1'b1;
                    // Requests arriving mid-flight are resolved against the
                    // in-flight address once the ack arrives.
                    if (i_ibus_ack) begin
                        o_ibus_cyc <= 1'b0;
                        pend       <= 1'b0;
                        discard    <= 1'b0;
                        state      <= IDLE;
                        if (pend_any && spec_match) begin
                            o_wb_en  <= 1'b1;
                            o_wb_rdt <= i_ibus_rdt[31:2];
                            launch   <= 1'b1;
                            nxt_tag  <= o_ibus_adr[31:2] + 30'd1;
                        end else if (pend_any) begin
                            state      <= DEMAND;
                            o_ibus_cyc <= 1'b1;
                            o_ibus_adr <= {pend_sel, 2'b00};
                        end else begin
                            buf_vld <= ~drop;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == SPEC && i_fetch_req && !pend)
            pend_tag <= req_tag;
        if (state == SPEC && i_ibus_ack && !pend_any) begin
            buf_tag <= o_ibus_adr[31:2];
            buf_dat <= i_ibus_rdt[31:2];
        end
    end

`else
    assign unused_bits = ^{RESET_PC, i_flush, i_pc[1:0], i_ibus_rdt[1:0]};

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            o_ibus_cyc <= 1'b0;
            o_ibus_adr <= '0;
            o_wb_en    <= 1'b0;
            o_wb_rdt   <= '0;
        end else begin
            o_wb_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_fetch_req) begin
                        state      <= DEMAND;
                        o_ibus_cyc <= 1'b1;
                        o_ibus_adr <= {req_tag, 2'b00};
                    end
                end
                DEMAND: begin
                    if (i_ibus_ack) begin
                        state      <= IDLE;
                        o_ibus_cyc <= 1'b0;
                        o_wb_en    <= 1'b1;
                        o_wb_rdt   <= i_ibus_rdt[31:2];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule
